// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and default sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 20000;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_winner,
  output logic                       o_any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  always_comb begin
    o_any    = 1'b0;
    o_winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W-1:0] w_idx;
      w_idx = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_any    = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters with round-robin grants.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic             r_tx_start, w_tx_start_nxt;
  logic             r_busy, w_busy_nxt;

  logic [IDX_W-1:0] w_winner;
  logic             w_any;
  logic [7:0]       w_win_data;

  uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Byte lane of the current winner.
  always_comb begin
    w_win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) w_win_data = req_data[8*i +: 8];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_timeout_err, w_timeout_nxt;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = |TIMEOUT_CYC;
  assign timeout_err  = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_tx_data_nxt  = r_tx_data;
    w_gnt_nxt      = '0;
    w_tx_start_nxt = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_timeout_nxt  = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_nxt    = w_winner;
          w_tx_data_nxt  = w_win_data;
          w_gnt_nxt      = NUM_REQ'(1) << w_winner;
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        w_ptr_nxt   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
        w_state_nxt = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
      end
      WAIT_DONE: begin
        if (tx_done) begin
          w_state_nxt = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (w_cnt_inc == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt   = IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_tx_data     <= '0;
      r_gnt         <= '0;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_owner       <= w_owner_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_gnt         <= w_gnt_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_busy        <= w_busy_nxt;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_timeout_nxt;
`endif
    end
  end

  assign gnt      = r_gnt;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign owner    = r_owner;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (optional UART_ARB_TIMEOUT_EN path included).
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 50;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [8*NR-1:0] req_data = '0;
  logic            tx_done = 1'b0;
  logic [NR-1:0]   gnt;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [1:0]      owner;
  logic            busy;
  logic            timeout_err;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   lat;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; invariants checked every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    check("start_with_gnt", 32'(tx_start), 32'(|gnt));
  endtask

  task automatic push(input int idx, input logic [7:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_start(input string tag, input int budget, output int n_lat);
    exp_t          e;
    logic [NR-1:0] exp_gnt;
    n_lat = -1;
    for (int n = 1; n <= budget; n++) begin
      step();
      if (tx_start === 1'b1) begin
        n_lat = n;
        break;
      end
    end
    check({tag, "_tx_start_seen"}, 32'(tx_start), 32'd1);
    if (tx_start === 1'b1) begin
      check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e       = sb.pop_front();
        exp_gnt = NR'(1) << e.idx;
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_tx_data"}, 32'(tx_data), 32'(e.data));
        check({tag, "_owner"}, 32'(owner), 32'(e.idx));
        check({tag, "_busy"}, 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst = 1'b0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};

    // Single request from requester 2
    req = 4'b0100;
    push(2, 8'hA5);
    wait_start("single", 5, lat);
    check("single_latency", 32'(lat), 32'd1);
    req = '0;
    repeat (3) step();
    check("single_busy_wait", 32'(busy), 32'd1);
    check("single_data_held", 32'(tx_data), 32'hA5);
    pulse_done();
    check("single_busy_after_done", 32'(busy), 32'd0);
    check("single_data_after_done", 32'(tx_data), 32'hA5);

    // Wrap: pointer is now 3, requesters 3 and 0 pending
    req = 4'b1001;
    push(3, 8'h44);
    push(0, 8'h11);
    wait_start("wrap_a", 5, lat);
    req[3] = 1'b0;
    repeat (2) step();
    pulse_done();
    check("wrap_idle_busy", 32'(busy), 32'd0);
    check("wrap_idle_start", 32'(tx_start), 32'd0);
    wait_start("wrap_b", 5, lat);
    check("wrap_gap", 32'(lat), 32'd1);
    req[0] = 1'b0;
    step();
    pulse_done();

    // Reset in WAIT_DONE
    req = 4'b0010;
    push(1, 8'h22);
    wait_start("rstwd", 5, lat);
    req = '0;
    repeat (2) step();
    check("rstwd_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    step();
    check("rstwd_busy", 32'(busy), 32'd0);
    check("rstwd_gnt", 32'(gnt), 32'd0);
    check("rstwd_tx_start", 32'(tx_start), 32'd0);
    check("rstwd_owner", 32'(owner), 32'd0);
    rst = 1'b1;
    step();
    check("rstwd_after_gnt", 32'(gnt), 32'd0);
    check("rstwd_after_busy", 32'(busy), 32'd0);

    // Fairness from a freshly reset pointer
    req = 4'b1111;
    push(0, 8'h11);
    push(1, 8'h22);
    push(2, 8'hA5);
    push(3, 8'h44);
    push(0, 8'h11);
    for (int k = 0; k < 5; k++) begin
      wait_start("fair", 5, lat);
      check("fair_latency", 32'(lat), 32'd1);
      if (k == 4) req = '0;
      repeat (10) step();
      pulse_done();
      check("fair_idle_busy", 32'(busy), 32'd0);
    end
    step();
    check("fair_no_extra", 32'(tx_start), 32'd0);

    // tx_done during ISSUE is ignored; tx_done with a new request still passes IDLE
    req = 4'b0100;
    push(2, 8'hA5);
    wait_start("simul_a", 5, lat);
    req = '0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("done_in_issue_busy", 32'(busy), 32'd1);
    step();
    check("done_in_issue_busy2", 32'(busy), 32'd1);
    tx_done = 1'b1;
    req = 4'b0010;
    push(1, 8'h22);
    step();
    tx_done = 1'b0;
    check("coincident_idle_busy", 32'(busy), 32'd0);
    check("coincident_idle_start", 32'(tx_start), 32'd0);
    wait_start("simul_b", 5, lat);
    check("coincident_latency", 32'(lat), 32'd1);
    req = '0;
    repeat (2) step();
    pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("done_in_idle_busy", 32'(busy), 32'd0);
    check("done_in_idle_start", 32'(tx_start), 32'd0);
    step();
    check("done_in_idle_busy2", 32'(busy), 32'd0);

    // No tx_done: watchdog abort or indefinite wait
    req = 4'b0001;
    push(0, 8'h11);
    wait_start("to", 5, lat);
    req = '0;
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int n_to;
      n_to = 0;
      for (int n = 1; n <= 80; n++) begin
        step();
        if (timeout_err === 1'b1) begin
          n_to = n;
          break;
        end
      end
      check("timeout_cycle", 32'(n_to), 32'(TO));
      check("timeout_busy", 32'(busy), 32'd0);
      req = 4'b1000;
      push(3, 8'h44);
      wait_start("after_to", 5, lat);
      check("timeout_single_pulse", 32'(timeout_err), 32'd0);
      req = '0;
      step();
      pulse_done();
    end
`else
    repeat (80) step();
    check("no_to_busy", 32'(busy), 32'd1);
    check("no_to_err", 32'(timeout_err), 32'd0);
    pulse_done();
    check("no_to_released", 32'(busy), 32'd0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
